// File: rtl/led_status_array.sv
// Multi-channel status LED driver: per-channel follow/sticky/blink modes with
// event stretching, a shared blink phase generator and a global enable gate.
module led_status_array #(
  parameter int CH        = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int STRETCH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CH-1:0]   ev,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   led,
  output logic [CH-1:0]   latched,
  output logic            any_latched
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] STR_LOAD = SW'(STRETCH);

  logic [CW-1:0] cnt;
  logic          phase;
  logic [SW-1:0] str [CH];
  logic [CH-1:0] lat;
  logic [CH-1:0] act;
  logic [CH-1:0] lat_nxt;
  logic [CH-1:0] led_nxt;

  // mode bit 0 selects sticky behaviour, mode bit 1 gates the output with phase
  always_comb begin
    act     = '0;
    lat_nxt = '0;
    led_nxt = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      act[i]     = ev[i] | (str[i] != '0);
      lat_nxt[i] = (ev[i] & mode[2*i]) | (lat[i] & ~clr[i]);
      led_nxt[i] = en & (act[i] | (mode[2*i] & lat[i])) & (~mode[2*i+1] | phase);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      lat   <= '0;
      led   <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        str[i] <= '0;
      end
    end else begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
      for (int unsigned i = 0; i < CH; i++) begin
        if (ev[i]) begin
          str[i] <= STR_LOAD;
        end else if (str[i] != '0) begin
          str[i] <= str[i] - SW'(1);
        end
      end
      lat <= lat_nxt;
      led <= led_nxt;
    end
  end

  assign latched     = lat;
  assign any_latched = |lat;

endmodule

// File: tb/tb_led_status_array.sv
// Randomized and directed bench for led_status_array against a cycle-count
// based reference model (CH=4, BLINK_DIV=4, STRETCH=3).
module tb_led_status_array;

  localparam int CH  = 4;
  localparam int DIV = 4;
  localparam int STR = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b1;
  logic [CH-1:0]   ev  = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0]   clr = '0;
  logic [CH-1:0]   led;
  logic [CH-1:0]   latched;
  logic            any_latched;

  int checks = 0;
  int errors = 0;

  // Reference model: n = edges since reset, last_ev = edge index of last event.
  int          n;
  int          last_ev [CH];
  logic [CH-1:0] lat_m;
  logic [CH-1:0] led_m;

  led_status_array #(.CH(CH), .BLINK_DIV(DIV), .STRETCH(STR)) dut (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .mode(mode), .clr(clr),
    .led(led), .latched(latched), .any_latched(any_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    logic act;
    logic ph;
    @(posedge clk);
    if (rst) begin
      n = 0;
      for (int i = 0; i < CH; i++) last_ev[i] = -1000;
      lat_m = '0;
      led_m = '0;
    end else begin
      ph = ((n / DIV) % 2) == 1;
      for (int i = 0; i < CH; i++) begin
        act = ev[i] || ((n - last_ev[i]) < STR);
        case (mode[2*i +: 2])
          2'b00:   led_m[i] = act;
          2'b01:   led_m[i] = act || lat_m[i];
          2'b10:   led_m[i] = act && ph;
          default: led_m[i] = (act || lat_m[i]) && ph;
        endcase
        if (!en) led_m[i] = 1'b0;
      end
      n = n + 1;
      for (int i = 0; i < CH; i++) begin
        if (ev[i] && mode[2*i]) lat_m[i] = 1'b1;
        else if (clr[i])        lat_m[i] = 1'b0;
        if (ev[i]) last_ev[i] = n;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev = '0; clr = '0; en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev = 4'($urandom); clr = 4'($urandom); en = 1'b1; mode = 8'hFF;
    tick(); tick();
    checks++;
    if (led !== 4'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
    checks++;
    if (latched !== 4'h0) begin errors++; $display("FAIL reset_latched: got %h want 0", latched); end
    checks++;
    if (any_latched !== 1'b0) begin errors++; $display("FAIL reset_any: got %b want 0", any_latched); end
    rst = 1'b0; ev = '0; clr = '0; mode = '0;
  endtask

  task automatic test_follow();
    do_reset();
    mode = 8'h00;
    tick(); tick();
    ev[0] = 1'b1;
    tick();
    ev[0] = 1'b0;
    checks++;
    if (led[0] !== 1'b1) begin errors++; $display("FAIL follow_first: got %b want 1", led[0]); end
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (led[0] !== (j < STR)) begin
        errors++; $display("FAIL follow_stretch[%0d]: got %b want %b", j, led[0], (j < STR));
      end
      checks++;
      if (led !== led_m) begin errors++; $display("FAIL follow_model[%0d]: got %h want %h", j, led, led_m); end
    end
  endtask

  task automatic test_sticky();
    do_reset();
    mode = 8'b0000_0100;
    ev[1] = 1'b1;
    tick();
    ev[1] = 1'b0;
    checks++;
    if (latched[1] !== 1'b1) begin errors++; $display("FAIL sticky_latched: got %b want 1", latched[1]); end
    checks++;
    if (any_latched !== 1'b1) begin errors++; $display("FAIL sticky_any: got %b want 1", any_latched); end
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (led[1] !== 1'b1) begin errors++; $display("FAIL sticky_hold[%0d]: got %b want 1", j, led[1]); end
    end
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    checks++;
    if (latched[1] !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b want 0", latched[1]); end
    checks++;
    if (any_latched !== 1'b0) begin errors++; $display("FAIL sticky_clr_any: got %b want 0", any_latched); end
    tick();
    checks++;
    if (led[1] !== 1'b0) begin errors++; $display("FAIL sticky_off: got %b want 0", led[1]); end
  endtask

  task automatic test_collision();
    do_reset();
    mode = 8'b0000_0100;
    ev[1] = 1'b1; clr[1] = 1'b1;
    tick();
    ev[1] = 1'b0; clr[1] = 1'b0;
    checks++;
    if (latched[1] !== 1'b1) begin errors++; $display("FAIL collision: got %b want 1", latched[1]); end
  endtask

  task automatic test_blink();
    mode = 8'b0010_0000;
    rst = 1'b1; clr = '0; en = 1'b1; ev = 4'b0100;
    tick();
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++;
      if (led[2] !== (((j - 1) / DIV) % 2 == 1)) begin
        errors++; $display("FAIL blink[%0d]: got %b want %b", j, led[2], (((j - 1) / DIV) % 2 == 1));
      end
    end
    ev = '0;
  endtask

  task automatic test_enable();
    do_reset();
    mode = 8'b1100_0000;
    ev[3] = 1'b1;
    tick();
    ev[3] = 1'b0;
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (led[3] !== 1'b0) begin errors++; $display("FAIL enable_off[%0d]: got %b want 0", j, led[3]); end
      checks++;
      if (latched[3] !== 1'b1) begin errors++; $display("FAIL enable_lat[%0d]: got %b want 1", j, latched[3]); end
    end
    en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      checks++;
      if (led !== led_m) begin errors++; $display("FAIL enable_resume[%0d]: got %h want %h", j, led, led_m); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 8'b0000_0100;
    for (int j = 0; j < 5; j++) tick();
    ev = 4'b0011;
    tick();
    ev = '0;
    tick();
    rst = 1'b1; en = 1'b1; ev = 4'hF; clr = '0; mode = 8'b1010_1010;
    tick();
    checks++;
    if (led !== 4'h0) begin errors++; $display("FAIL midreset_led: got %h want 0", led); end
    checks++;
    if (latched !== 4'h0) begin errors++; $display("FAIL midreset_lat: got %h want 0", latched); end
    checks++;
    if (any_latched !== 1'b0) begin errors++; $display("FAIL midreset_any: got %b want 0", any_latched); end
    rst = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (led !== {CH{((j - 1) / DIV) % 2 == 1}}) begin
        errors++; $display("FAIL midreset_blink[%0d]: got %h want %h", j, led, {CH{((j - 1) / DIV) % 2 == 1}});
      end
    end
    ev = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 600; j++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 7) != 0);
      ev   = 4'($urandom) & 4'($urandom);
      clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      tick();
      checks++;
      if (led !== led_m) begin errors++; $display("FAIL rand_led[%0d]: got %h want %h", j, led, led_m); end
      checks++;
      if (latched !== lat_m) begin errors++; $display("FAIL rand_lat[%0d]: got %h want %h", j, latched, lat_m); end
      checks++;
      if (any_latched !== (|lat_m)) begin
        errors++; $display("FAIL rand_any[%0d]: got %b want %b", j, any_latched, |lat_m);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #3;
    test_reset();
    test_follow();
    test_sticky();
    test_collision();
    test_blink();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_array.md
LED_STATUS_ARRAY -- requirements
Module: led_status_array

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent indicator channels (1..32).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25_000_000, meaning clk cycles per blink half-period (>=1).
REQ-003 The block SHALL have parameter STRETCH, default 8, meaning the minimum extra on-time in clk cycles after an event deasserts (0 disables).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port en  input  1  global display enable.
REQ-007 The block SHALL have port ev  input  CH  per-channel event level (e.g. min, timeout).
REQ-008 The block SHALL have port mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 follow, 01 sticky, 10 blink, 11 sticky-blink.
REQ-009 The block SHALL have port clr  input  CH  per-channel latch clear.
REQ-010 The block SHALL have port led  output  CH  registered LED drive.
REQ-011 The block SHALL have port latched  output  CH  sticky latch state per channel.
REQ-012 The block SHALL have port any_latched  output  1  OR of all latched bits.

Function
REQ-013 The blink counter SHALL be shared by all channels, count 0..BLINK_DIV-1, wrap to 0 at BLINK_DIV-1, and toggle phase on that wrap cycle.
REQ-014 Each channel SHALL have a stretch counter that loads STRETCH while ev[i]=1 and decrements by 1 while ev[i]=0 and it is nonzero, saturating at 0.
REQ-015 Active SHALL be defined as act[i] = ev[i] OR (stretch counter != 0), so act stays high for exactly STRETCH cycles after ev[i] falls.
REQ-016 The latch lat[i] SHALL set on any cycle with ev[i]=1 while mode[i] is 01 or 11.
REQ-017 The latch SHALL clear on clr[i]=1.
REQ-018 When set and clear coincide on one cycle, set SHALL win.
REQ-019 In modes 00 and 10 the latch SHALL hold its value, with no set and clear still honoured.
REQ-020 With en=1, led[i] SHALL be registered with one-cycle latency as follows: mode 00 = act; 01 = act|lat; 10 = act&phase; 11 = (act|lat)&phase.
REQ-021 With en=0, led SHALL be registered to all zeros, while the counters, phase and latches continue to update.
REQ-022 A mode change SHALL take effect on the next led update, with no counter or latch disturbance.
REQ-023 The latched output SHALL equal the lat registers directly, with zero added latency.
REQ-024 any_latched SHALL equal the reduction OR of lat.
REQ-025 The blink counter and each stretch counter SHALL be sized to ceil(log2(max+1)) bits, with no overflow for any legal parameter value.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL clear the blink counter to 0 and set phase to 0 (off).
REQ-027 While rst=1 at a clk edge, the block SHALL clear all stretch counters, lat, led, latched and any_latched to 0.
REQ-028 Reset SHALL override ev, clr and en on that edge.
REQ-029 A reset asserted mid-blink or mid-stretch SHALL abort the operation, and counting SHALL restart from 0 on the first edge after rst falls.

Verification (CH=4, BLINK_DIV=4, STRETCH=3)
REQ-030 Bench scenario follow/stretch: mode0=00, ev[0] high for 1 cycle at edge k -> led[0]=1 at edges k+1..k+4, then 0.
REQ-031 Bench scenario sticky: mode1=01, ev[1] pulses once -> latched[1]=1 and any_latched=1 from the next edge, led[1] stays 1 indefinitely; clr[1]=1 -> latched[1]=0 at the next edge and led[1]=0 once the stretch has expired.
REQ-032 Bench scenario set/clear collision: mode1=01, ev[1]=1 and clr[1]=1 on the same edge -> latched[1]=1.
REQ-033 Bench scenario blink: mode2=10, ev[2] held high -> led[2] toggles every 4 cycles (period 8), with the first on half-period starting after the first wrap following reset.
REQ-034 Bench scenario enable gating: mode3=11, latch set, en=0 for 10 cycles -> led[3]=0 throughout while latched[3]=1; en back to 1 -> blinking resumes in phase with the free-running counter.
REQ-035 Bench scenario reset mid-operation: rst=1 for 1 cycle during a stretch with latches set -> all outputs 0 on the next edge, blink counter restarts from 0.
